// File: rtl/cve2_obi_arbiter.sv
// Shares one OBI memory port between instruction fetch and LSU; responses are routed back in order
// via a source-tag FIFO. Define CVE2_OBI_ARB_RR_EN for round-robin arbitration instead of data-first.
module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_req_i,
  output logic                 instr_gnt_o,
  input  logic [AddrWidth-1:0] instr_addr_i,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [AddrWidth-1:0] data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_err_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [MaxOutstanding-1:0] tag_q, tag_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                      lock_q, lock_d, lock_src_q, lock_src_d;
  logic                      full, any_req, sel_data, push, pop, head_tag;

`ifdef CVE2_OBI_ARB_RR_EN
  logic rr_last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_q <= 1'b0;
    end else if (push) begin
      rr_last_q <= sel_data;
    end
  end
`endif

  assign full     = (cnt_q == CntMax);
  assign any_req  = instr_req_i | data_req_i;
  assign head_tag = tag_q[rd_ptr_q];

  // A locked source keeps the port until granted so its address stays stable.
  always_comb begin
    sel_data = 1'b0;
    if (lock_q) begin
      sel_data = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
`ifdef CVE2_OBI_ARB_RR_EN
      sel_data = ~rr_last_q;
`else
      sel_data = 1'b1;
`endif
    end else begin
      sel_data = data_req_i;
    end
  end

  assign mem_req_o   = any_req & ~full;
  assign mem_we_o    = mem_req_o & sel_data & data_we_i;
  assign mem_be_o    = !mem_req_o ? 4'h0 : (sel_data ? data_be_i : 4'hF);
  assign mem_addr_o  = !mem_req_o ? '0 : (sel_data ? data_addr_i : instr_addr_i);
  assign mem_wdata_o = (mem_req_o && sel_data) ? data_wdata_i : 32'h0;

  assign push        = mem_req_o & mem_gnt_i;
  assign pop         = mem_rvalid_i & (cnt_q != '0);
  assign instr_gnt_o = push & ~sel_data;
  assign data_gnt_o  = push & sel_data;

  assign instr_rvalid_o = pop & ~head_tag;
  assign data_rvalid_o  = pop & head_tag;
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_comb begin
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push) begin
      tag_d[wr_ptr_q] = sel_data;
      wr_ptr_d        = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_src_d = sel_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end

`ifndef SYNTHESIS
  a_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({instr_req_i, data_req_i, mem_gnt_i, mem_rvalid_i}));
  a_one_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_gnt_o && data_gnt_o));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntMax);
  // A stray response is dropped in hardware; flag it without stopping simulation.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (cnt_q != '0))
    else $warning("mem_rvalid_i received with no outstanding transaction");
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> (lock_src_q ? data_req_i : instr_req_i));
`endif

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Randomized and directed bench for cve2_obi_arbiter against a queue-based reference model.
module tb_cve2_obi_arbiter;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq, dreq, dwe, mgnt, mrv, merr;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [3:0]  dbe;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;

  int checks = 0;
  int errors = 0;

  // reference model: outstanding source tags, committed-but-ungranted source, last granted source
  bit q[$];
  int pend = -1;
  bit last_data = 1'b0;
  bit g_i, g_d;

  always #5 clk = ~clk;

  cve2_obi_arbiter #(.MaxOutstanding(MAXO), .AddrWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(ireq), .instr_gnt_o(instr_gnt_o), .instr_addr_i(iaddr),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(dreq), .data_gnt_o(data_gnt_o), .data_we_i(dwe), .data_be_i(dbe),
    .data_addr_i(daddr), .data_wdata_i(dwdata),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mgnt), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mrv), .mem_rdata_i(mrdata), .mem_err_i(merr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit full, ereq, sel, g, pop, head;
    full = (q.size() == MAXO);
    ereq = (ireq || dreq) && !full;
    if (pend >= 0) sel = (pend == 1);
    else if (ireq && dreq) begin
`ifdef CVE2_OBI_ARB_RR_EN
      sel = !last_data;
`else
      sel = 1'b1;
`endif
    end else sel = dreq;
    g = ereq && mgnt;
    pop = mrv && (q.size() > 0);
    head = pop ? q[0] : 1'b0;
    chk("mem_req", 32'(mem_req_o), 32'(ereq));
    chk("mem_we", 32'(mem_we_o), 32'(ereq && sel && dwe));
    chk("mem_be", 32'(mem_be_o), !ereq ? 32'h0 : (sel ? 32'(dbe) : 32'hF));
    chk("mem_addr", mem_addr_o, !ereq ? 32'h0 : (sel ? daddr : iaddr));
    chk("mem_wdata", mem_wdata_o, (ereq && sel) ? dwdata : 32'h0);
    chk("instr_gnt", 32'(instr_gnt_o), 32'(g && !sel));
    chk("data_gnt", 32'(data_gnt_o), 32'(g && sel));
    chk("instr_rvalid", 32'(instr_rvalid_o), 32'(pop && !head));
    chk("data_rvalid", 32'(data_rvalid_o), 32'(pop && head));
    chk("instr_err", 32'(instr_err_o), 32'(pop && !head && merr));
    chk("data_err", 32'(data_err_o), 32'(pop && head && merr));
    chk("instr_rdata", instr_rdata_o, mrdata);
    chk("data_rdata", data_rdata_o, mrdata);
    if (pop) void'(q.pop_front());
    if (g) begin
      q.push_back(sel);
      pend = -1;
      last_data = sel;
    end else if (ereq) pend = sel ? 1 : 0;
    g_i = g && !sel;
    g_d = g && sel;
  endtask

  task automatic finish_cycle();
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic idle_inputs();
    ireq = 0; dreq = 0; dwe = 0; mgnt = 0; mrv = 0; merr = 0;
    iaddr = 0; daddr = 0; dwdata = 0; mrdata = 0; dbe = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    q.delete();
    pend = -1;
    last_data = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  bit exp_order[4];

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_mem_be", 32'(mem_be_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_gnts", 32'({instr_gnt_o, data_gnt_o}), 0);
    chk("rst_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 0);
    finish_cycle();

    // stray response straight out of reset
    mrv = 1; mrdata = 32'h1234;
    @(negedge clk);
    chk("empty_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 0);
    finish_cycle();
    mrv = 0;

    // single instruction read
    ireq = 1; iaddr = 32'h80; mgnt = 1;
    @(negedge clk);
    chk("single_gnt", 32'(instr_gnt_o), 1);
    chk("single_addr", mem_addr_o, 32'h80);
    finish_cycle();
    ireq = 0; mgnt = 0;
    cycle();
    mrv = 1; mrdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("single_rvalid", 32'(instr_rvalid_o), 1);
    chk("single_rdata", instr_rdata_o, 32'hDEADBEEF);
    chk("single_drvalid", 32'(data_rvalid_o), 0);
    finish_cycle();
    mrv = 0;
    cycle();

    // simultaneous requests: data first, then instr, responses in order
    ireq = 1; iaddr = 32'h100; dreq = 1; daddr = 32'h200; dwe = 1; dbe = 4'h3;
    dwdata = 32'hCAFE0001; mgnt = 1;
    @(negedge clk);
    chk("both_addr", mem_addr_o, 32'h200);
    chk("both_dgnt", 32'(data_gnt_o), 1);
    chk("both_be", 32'(mem_be_o), 32'h3);
    chk("both_we", 32'(mem_we_o), 1);
    finish_cycle();
    dreq = 0; dwe = 0; dbe = 0; dwdata = 0;
    @(negedge clk);
    chk("both_addr2", mem_addr_o, 32'h100);
    chk("both_igant", 32'(instr_gnt_o), 1);
    finish_cycle();
    ireq = 0; mgnt = 0; mrv = 1; mrdata = 32'h11;
    @(negedge clk);
    chk("both_resp1", 32'({instr_rvalid_o, data_rvalid_o}), 32'b01);
    finish_cycle();
    mrdata = 32'h22;
    @(negedge clk);
    chk("both_resp2", 32'({instr_rvalid_o, data_rvalid_o}), 32'b10);
    finish_cycle();
    mrv = 0;

    // lock: data held without grant, instr arrives late
    dreq = 1; daddr = 32'h300; mgnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin ireq = 1; iaddr = 32'h400; end
      if (c == 3) mgnt = 1;
      @(negedge clk);
      chk("lock_addr", mem_addr_o, 32'h300);
      chk("lock_dgnt", 32'(data_gnt_o), (c == 3) ? 1 : 0);
      finish_cycle();
    end
    dreq = 0;
    @(negedge clk);
    chk("lock_addr_after", mem_addr_o, 32'h400);
    chk("lock_igant_after", 32'(instr_gnt_o), 1);
    finish_cycle();
    ireq = 0; mgnt = 0; mrv = 1;
    repeat (2) cycle();
    mrv = 0;

    // sustained conflict: arbitration order over four grants
`ifdef CVE2_OBI_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    ireq = 1; iaddr = 32'h600; dreq = 1; daddr = 32'h700; dbe = 4'hF; mgnt = 1;
    for (int k = 0; k < 4; k++) begin
      mrv = (k > 0);
      @(negedge clk);
      chk("order_dgnt", 32'(data_gnt_o), 32'(exp_order[k]));
      finish_cycle();
    end
    ireq = 0; dreq = 0; dbe = 0; mgnt = 0; mrv = 1;
    cycle();
    mrv = 0;
    cycle();

    // full: two outstanding blocks the port, pop does not bypass
    ireq = 1; iaddr = 32'h500; mgnt = 1;
    repeat (2) cycle();
    @(negedge clk);
    chk("full_req", 32'(mem_req_o), 0);
    finish_cycle();
    mrv = 1;
    @(negedge clk);
    chk("full_pop_req", 32'(mem_req_o), 0);
    chk("full_pop_gnt", 32'(instr_gnt_o), 0);
    chk("full_pop_rvalid", 32'(instr_rvalid_o), 1);
    finish_cycle();
    mrv = 0;
    @(negedge clk);
    chk("full_next_req", 32'(mem_req_o), 1);
    chk("full_next_gnt", 32'(instr_gnt_o), 1);
    finish_cycle();
    ireq = 0; mgnt = 0; mrv = 1;
    repeat (2) cycle();
    mrv = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (ireq && g_i) ireq = 0;
      if (!ireq && $urandom_range(0, 2) == 0) begin ireq = 1; iaddr = $urandom; end
      if (dreq && g_d) dreq = 0;
      if (!dreq && $urandom_range(0, 2) == 0) begin
        dreq = 1; daddr = $urandom; dwe = $urandom_range(0, 1);
        dbe = 4'($urandom); dwdata = $urandom;
      end
      mgnt = ($urandom_range(0, 9) < 6);
      mrv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mrdata = $urandom;
      merr = ($urandom_range(0, 7) == 0);
      cycle();
    end

    // reset with a transaction outstanding, then a stray response
    idle_inputs();
    ireq = 1; iaddr = 32'h900; mgnt = 1;
    cycle();
    do_reset();
    mrv = 1; mrdata = 32'h55;
    @(negedge clk);
    chk("rst_stray_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 0);
    finish_cycle();
    mrv = 0; ireq = 1; iaddr = 32'hA00; mgnt = 1;
    cycle();
    ireq = 0; mgnt = 0; mrv = 1; mrdata = 32'h66;
    @(negedge clk);
    chk("rst_after_rvalid", 32'(instr_rvalid_o), 1);
    finish_cycle();
    mrv = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
